// File: rtl/csi_decoder_scheduler_pkg.sv
// Shared CSI-2 data type codes, decoder/state enums and error bit positions
// for the decoder scheduler slice.
package csi_pkg;

    localparam logic [5:0] DT_FS       = 6'h00;
    localparam logic [5:0] DT_FE       = 6'h01;
    localparam logic [5:0] DT_LS       = 6'h02;
    localparam logic [5:0] DT_LE       = 6'h03;
    localparam logic [5:0] DT_YUV422_8 = 6'h1E;
    localparam logic [5:0] DT_RGB565   = 6'h22;
    localparam logic [5:0] DT_RAW8     = 6'h2A;

    // CSI-2 reserves codes below 0x10 for short packets
    localparam logic [5:0] DT_LONG_MIN = 6'h10;

    localparam int ERR_UNSUPPORTED = 0;
    localparam int ERR_TRUNCATED   = 1;
    localparam int ERR_NO_FRAME    = 2;

    typedef enum logic [1:0] {
        DEC_NONE   = 2'd0,
        DEC_RGB565 = 2'd1,
        DEC_RAW8   = 2'd2,
        DEC_YUV422 = 2'd3
    } decoder_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    function automatic decoder_t dt_to_decoder(input logic [5:0] dt);
        decoder_t d;
        case (dt)
            DT_RGB565:   d = DEC_RGB565;
            DT_RAW8:     d = DEC_RAW8;
            DT_YUV422_8: d = DEC_YUV422;
            default:     d = DEC_NONE;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/csi_decoder_scheduler_if.sv
// Parser-side header/payload inputs and decoder-side outputs of the scheduler.
// master = packet parser / decoders side, slave = the scheduler.
interface csi_decoder_scheduler_if #(
    parameter int WC_WIDTH = 16
);
    import csi_pkg::*;

    logic                header_valid;
    logic [1:0]          virtual_channel;
    logic [5:0]          data_type;
    logic [WC_WIDTH-1:0] word_count;
    logic [31:0]         payload_data;
    logic                payload_valid;
    logic                error_clear;

    logic [31:0]         image_data;
    logic                image_data_enable;
    logic [3:0]          byte_enable;
    decoder_t            decoder_select;
    logic                payload_last;
    logic                frame_active;
    logic [WC_WIDTH-1:0] line_number;
    logic [15:0]         frame_number;
    logic [2:0]          error;

    modport master (
        output header_valid, virtual_channel, data_type, word_count,
               payload_data, payload_valid, error_clear,
        input  image_data, image_data_enable, byte_enable, decoder_select,
               payload_last, frame_active, line_number, frame_number, error
    );

    modport slave (
        input  header_valid, virtual_channel, data_type, word_count,
               payload_data, payload_valid, error_clear,
        output image_data, image_data_enable, byte_enable, decoder_select,
               payload_last, frame_active, line_number, frame_number, error
    );

endinterface

// File: rtl/csi_payload_counter.sv
// Remaining-byte countdown for a long packet payload; yields the byte enables
// for the current word and whether that word is the packet's last.
module csi_payload_counter #(
    parameter int WC_WIDTH = 16
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_load,
    input  logic [WC_WIDTH-1:0] i_load_value,
    input  logic                i_consume,
    output logic [3:0]          o_byte_enable,
    output logic                o_last
);

    localparam logic [WC_WIDTH-1:0] WORD_BYTES = WC_WIDTH'(4);

    logic [WC_WIDTH-1:0] r_remaining;
    logic                w_full_word;

    assign w_full_word = (r_remaining >= WORD_BYTES);
    assign o_last      = (r_remaining <= WORD_BYTES);

    always_comb begin
        o_byte_enable = 4'b1111;
        if (!w_full_word) begin
            case (r_remaining[1:0])
                2'd0:    o_byte_enable = 4'b0000;
                2'd1:    o_byte_enable = 4'b0001;
                2'd2:    o_byte_enable = 4'b0011;
                default: o_byte_enable = 4'b0111;
            endcase
        end
    end

    // Load takes priority: a new header always restarts the countdown
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_remaining <= '0;
        end else if (i_load) begin
            r_remaining <= i_load_value;
        end else if (i_consume) begin
            r_remaining <= w_full_word ? (r_remaining - WORD_BYTES) : '0;
        end
    end

endmodule

// File: rtl/csi_decoder_scheduler.sv
// Routes CSI-2 long-packet payload to the selected pixel decoder, tracking
// frame/line state from short packets and flagging protocol errors.
module csi_decoder_scheduler
    import csi_pkg::*;
#(
    parameter int VIRTUAL_CHANNEL = 0,
    parameter int WC_WIDTH        = 16
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    csi_decoder_scheduler_if.slave   bus
);

    state_t              r_state, w_state_nxt;

    logic [31:0]         r_image_data;
    logic                r_image_data_enable;
    logic [3:0]          r_byte_enable;
    decoder_t            r_decoder_select;
    logic                r_payload_last;
    logic                r_frame_active;
    logic [WC_WIDTH-1:0] r_line_number;
    logic [15:0]         r_frame_number;
    logic [2:0]          r_error;

    logic                w_vc_match, w_long, w_supported, w_wc_nonzero;
    logic                w_consume, w_forward;
    logic                w_cnt_load, w_cnt_last;
    logic [WC_WIDTH-1:0] w_cnt_load_value;
    logic [3:0]          w_cnt_byte_enable;
    logic [2:0]          w_err_set;
    logic                w_frame_start, w_frame_end, w_line_inc, w_dec_latch;

    assign w_vc_match   = (bus.virtual_channel == 2'(VIRTUAL_CHANNEL));
    assign w_long       = (bus.data_type >= DT_LONG_MIN);
    assign w_supported  = (dt_to_decoder(bus.data_type) != DEC_NONE);
    assign w_wc_nonzero = (bus.word_count != '0);

    // A header in the same cycle pre-empts any payload word
    assign w_consume = bus.payload_valid && !bus.header_valid && (r_state != S_IDLE);
    assign w_forward = w_consume && (r_state == S_PAYLOAD);

    csi_payload_counter #(.WC_WIDTH(WC_WIDTH)) u_counter (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_load        (w_cnt_load),
        .i_load_value  (w_cnt_load_value),
        .i_consume     (w_consume),
        .o_byte_enable (w_cnt_byte_enable),
        .o_last        (w_cnt_last)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_load       = 1'b0;
        w_cnt_load_value = '0;
        w_err_set        = '0;
        w_frame_start    = 1'b0;
        w_frame_end      = 1'b0;
        w_line_inc       = 1'b0;
        w_dec_latch      = 1'b0;

        if (bus.header_valid) begin
            // Any header aborts the packet in flight and is decoded as from IDLE
            w_cnt_load  = 1'b1;
            w_state_nxt = S_IDLE;
            if (r_state == S_PAYLOAD) w_err_set[ERR_TRUNCATED] = 1'b1;

            if (w_long) begin
                if (w_vc_match) begin
                    if (!w_supported)    w_err_set[ERR_UNSUPPORTED] = 1'b1;
                    if (!r_frame_active) w_err_set[ERR_NO_FRAME]    = 1'b1;
                end
                if (w_vc_match && w_supported && r_frame_active) begin
                    if (w_wc_nonzero) begin
                        w_dec_latch      = 1'b1;
                        w_cnt_load_value = bus.word_count;
                        w_state_nxt      = S_PAYLOAD;
                    end else begin
                        w_line_inc = 1'b1;
                    end
                end else if (w_wc_nonzero) begin
                    w_cnt_load_value = bus.word_count;
                    w_state_nxt      = S_DISCARD;
                end
            end else if (w_vc_match) begin
                w_frame_start = (bus.data_type == DT_FS);
                w_frame_end   = (bus.data_type == DT_FE);
            end
        end else if (w_consume && w_cnt_last) begin
            w_state_nxt = S_IDLE;
            w_line_inc  = (r_state == S_PAYLOAD);
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_image_data        <= '0;
            r_image_data_enable <= 1'b0;
            r_byte_enable       <= '0;
            r_decoder_select    <= DEC_NONE;
            r_payload_last      <= 1'b0;
            r_frame_active      <= 1'b0;
            r_line_number       <= '0;
            r_frame_number      <= '0;
            r_error             <= '0;
        end else begin
            r_image_data_enable <= w_forward;
            r_payload_last      <= w_forward && w_cnt_last;
            if (w_forward) begin
                r_image_data  <= bus.payload_data;
                r_byte_enable <= w_cnt_byte_enable;
            end
            if (w_dec_latch) r_decoder_select <= dt_to_decoder(bus.data_type);

            if (w_frame_start) begin
                r_frame_active <= 1'b1;
                r_line_number  <= '0;
                r_frame_number <= r_frame_number + 16'd1;
            end else if (w_frame_end) begin
                r_frame_active <= 1'b0;
            end else if (w_line_inc) begin
                r_line_number  <= r_line_number + WC_WIDTH'(1);
            end

            // A fresh error wins over a simultaneous clear
            r_error <= (bus.error_clear ? 3'b000 : r_error) | w_err_set;
        end
    end

    assign bus.image_data        = r_image_data;
    assign bus.image_data_enable = r_image_data_enable;
    assign bus.byte_enable       = r_byte_enable;
    assign bus.decoder_select    = r_decoder_select;
    assign bus.payload_last      = r_payload_last;
    assign bus.frame_active      = r_frame_active;
    assign bus.line_number       = r_line_number;
    assign bus.frame_number      = r_frame_number;
    assign bus.error             = r_error;

endmodule

// File: tb/tb_csi_decoder_scheduler.sv
// Directed bench for csi_decoder_scheduler: hand-computed expectations per scenario.
module tb_csi_decoder_scheduler;
    import csi_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    csi_decoder_scheduler_if #(.WC_WIDTH(16)) bus_if ();

    csi_decoder_scheduler #(.VIRTUAL_CHANNEL(0), .WC_WIDTH(16)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    // Observed outputs captured one cycle after each driven input
    logic        o_en, o_last;
    logic [3:0]  o_be;
    logic [31:0] o_img;

    task automatic sample();
        o_en   = bus_if.image_data_enable;
        o_last = bus_if.payload_last;
        o_be   = bus_if.byte_enable;
        o_img  = bus_if.image_data;
    endtask

    task automatic send_hdr(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                            input logic with_payload);
        bus_if.header_valid    = 1'b1;
        bus_if.virtual_channel = vc;
        bus_if.data_type       = dt;
        bus_if.word_count      = wc;
        bus_if.payload_valid   = with_payload;
        bus_if.payload_data    = 32'hDEAD_BEEF;
        @(negedge clk);
        bus_if.header_valid  = 1'b0;
        bus_if.payload_valid = 1'b0;
        sample();
    endtask

    task automatic send_word(input logic [31:0] d);
        bus_if.payload_valid = 1'b1;
        bus_if.payload_data  = d;
        @(negedge clk);
        bus_if.payload_valid = 1'b0;
        sample();
    endtask

    task automatic pulse_clear();
        bus_if.error_clear = 1'b1;
        @(negedge clk);
        bus_if.error_clear = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if (bus_if.image_data_enable !== 1'b0) begin n_bad++; $display("FAIL reset_en got %b want 0", bus_if.image_data_enable); end
        n_cmp++; if (bus_if.decoder_select !== DEC_NONE) begin n_bad++; $display("FAIL reset_dec got %0d want 0", bus_if.decoder_select); end
        n_cmp++; if ({bus_if.frame_active, bus_if.line_number, bus_if.frame_number, bus_if.error} !== '0) begin n_bad++; $display("FAIL reset_state got fa=%b ln=%0d fn=%0d err=%b want 0", bus_if.frame_active, bus_if.line_number, bus_if.frame_number, bus_if.error); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_no_frame();
        send_hdr(2'd0, DT_RAW8, 16'd4, 1'b0);
        send_word(32'hAABBCCDD);
        n_cmp++; if (o_en !== 1'b0) begin n_bad++; $display("FAIL noframe_en got %b want 0", o_en); end
        n_cmp++; if (bus_if.error !== 3'b100) begin n_bad++; $display("FAIL noframe_err got %b want 100", bus_if.error); end
        pulse_clear();
        n_cmp++; if (bus_if.error !== 3'b000) begin n_bad++; $display("FAIL noframe_clear got %b want 000", bus_if.error); end
    endtask

    task automatic test_rgb565();
        send_hdr(2'd0, DT_FS, 16'd0, 1'b0);
        n_cmp++; if (bus_if.frame_active !== 1'b1 || bus_if.frame_number !== 16'd1) begin n_bad++; $display("FAIL fs got fa=%b fn=%0d want 1/1", bus_if.frame_active, bus_if.frame_number); end
        send_hdr(2'd0, DT_RGB565, 16'd8, 1'b0);
        n_cmp++; if (o_en !== 1'b0) begin n_bad++; $display("FAIL rgb_pre_en got %b want 0", o_en); end
        send_word(32'h11223344);
        n_cmp++; if ({o_en, o_be, o_last, o_img} !== {1'b1, 4'hF, 1'b0, 32'h11223344}) begin n_bad++; $display("FAIL rgb_w0 got en=%b be=%h last=%b d=%h want 1/f/0/11223344", o_en, o_be, o_last, o_img); end
        send_word(32'h55667788);
        n_cmp++; if ({o_en, o_be, o_last, o_img} !== {1'b1, 4'hF, 1'b1, 32'h55667788}) begin n_bad++; $display("FAIL rgb_w1 got en=%b be=%h last=%b d=%h want 1/f/1/55667788", o_en, o_be, o_last, o_img); end
        n_cmp++; if (bus_if.decoder_select !== DEC_RGB565) begin n_bad++; $display("FAIL rgb_dec got %0d want 1", bus_if.decoder_select); end
        @(negedge clk); sample();
        n_cmp++; if (o_en !== 1'b0 || o_last !== 1'b0) begin n_bad++; $display("FAIL rgb_idle got en=%b last=%b want 0/0", o_en, o_last); end
        n_cmp++; if (bus_if.line_number !== 16'd1 || bus_if.frame_number !== 16'd1) begin n_bad++; $display("FAIL rgb_counts got ln=%0d fn=%0d want 1/1", bus_if.line_number, bus_if.frame_number); end
    endtask

    task automatic test_raw8_partial();
        send_hdr(2'd0, DT_RAW8, 16'd6, 1'b0);
        send_word(32'h01020304);
        n_cmp++; if ({o_en, o_be, o_last} !== {1'b1, 4'hF, 1'b0}) begin n_bad++; $display("FAIL raw8_w0 got en=%b be=%h last=%b want 1/f/0", o_en, o_be, o_last); end
        send_word(32'h05060708);
        n_cmp++; if ({o_en, o_be, o_last} !== {1'b1, 4'b0011, 1'b1}) begin n_bad++; $display("FAIL raw8_w1 got en=%b be=%h last=%b want 1/3/1", o_en, o_be, o_last); end
        n_cmp++; if (bus_if.decoder_select !== DEC_RAW8 || bus_if.line_number !== 16'd2) begin n_bad++; $display("FAIL raw8_state got dec=%0d ln=%0d want 2/2", bus_if.decoder_select, bus_if.line_number); end
    endtask

    task automatic test_vc_drop();
        logic any_en;
        any_en = 1'b0;
        send_hdr(2'd1, DT_RGB565, 16'd12, 1'b0);
        for (int i = 0; i < 3; i++) begin
            send_word(32'hC0DE_0000 + i);
            any_en |= o_en;
        end
        send_word(32'hFFFF0000);
        any_en |= o_en;
        n_cmp++; if (any_en !== 1'b0) begin n_bad++; $display("FAIL vc_en got %b want 0", any_en); end
        n_cmp++; if (bus_if.error !== 3'b000 || bus_if.line_number !== 16'd2) begin n_bad++; $display("FAIL vc_state got err=%b ln=%0d want 000/2", bus_if.error, bus_if.line_number); end
    endtask

    task automatic test_unsupported();
        send_hdr(2'd0, 6'h2B, 16'd8, 1'b0);
        send_word(32'h12345678);
        n_cmp++; if (o_en !== 1'b0) begin n_bad++; $display("FAIL unsup_en got %b want 0", o_en); end
        send_word(32'h9ABCDEF0);
        n_cmp++; if (o_en !== 1'b0 || bus_if.error !== 3'b001) begin n_bad++; $display("FAIL unsup_err got en=%b err=%b want 0/001", o_en, bus_if.error); end
        pulse_clear();
        n_cmp++; if (bus_if.error !== 3'b000) begin n_bad++; $display("FAIL unsup_clear got %b want 000", bus_if.error); end
        bus_if.error_clear = 1'b1;
        send_hdr(2'd0, 6'h2B, 16'd0, 1'b0);
        bus_if.error_clear = 1'b0;
        n_cmp++; if (bus_if.error !== 3'b001) begin n_bad++; $display("FAIL clear_vs_set got %b want 001", bus_if.error); end
        pulse_clear();
    endtask

    task automatic test_truncate();
        send_hdr(2'd0, DT_RGB565, 16'd16, 1'b0);
        send_word(32'hA0A0A0A0);
        n_cmp++; if (o_en !== 1'b1 || o_last !== 1'b0) begin n_bad++; $display("FAIL trunc_w0 got en=%b last=%b want 1/0", o_en, o_last); end
        send_hdr(2'd0, DT_RGB565, 16'd8, 1'b1);
        n_cmp++; if (o_en !== 1'b0 || o_last !== 1'b0) begin n_bad++; $display("FAIL trunc_collide got en=%b last=%b want 0/0", o_en, o_last); end
        n_cmp++; if (bus_if.error !== 3'b010 || bus_if.line_number !== 16'd2) begin n_bad++; $display("FAIL trunc_err got err=%b ln=%0d want 010/2", bus_if.error, bus_if.line_number); end
        send_word(32'hB1B1B1B1);
        send_word(32'hB2B2B2B2);
        n_cmp++; if ({o_en, o_be, o_last, o_img} !== {1'b1, 4'hF, 1'b1, 32'hB2B2B2B2}) begin n_bad++; $display("FAIL trunc_new got en=%b be=%h last=%b d=%h want 1/f/1/b2b2b2b2", o_en, o_be, o_last, o_img); end
        n_cmp++; if (bus_if.line_number !== 16'd3) begin n_bad++; $display("FAIL trunc_line got %0d want 3", bus_if.line_number); end
    endtask

    task automatic test_zero_wc();
        send_hdr(2'd0, DT_YUV422_8, 16'd0, 1'b0);
        send_word(32'h0F0F0F0F);
        n_cmp++; if (o_en !== 1'b0 || bus_if.line_number !== 16'd4) begin n_bad++; $display("FAIL zero_wc got en=%b ln=%0d want 0/4", o_en, bus_if.line_number); end
    endtask

    task automatic test_reset_mid();
        send_hdr(2'd0, DT_YUV422_8, 16'd8, 1'b0);
        send_word(32'h77777777);
        n_cmp++; if (o_en !== 1'b1 || bus_if.decoder_select !== DEC_YUV422) begin n_bad++; $display("FAIL mid_w0 got en=%b dec=%0d want 1/3", o_en, bus_if.decoder_select); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({bus_if.image_data_enable, bus_if.payload_last, bus_if.image_data, bus_if.byte_enable} !== '0) begin n_bad++; $display("FAIL mid_rst_out got en=%b last=%b d=%h be=%h want 0", bus_if.image_data_enable, bus_if.payload_last, bus_if.image_data, bus_if.byte_enable); end
        n_cmp++; if ({bus_if.frame_active, bus_if.line_number, bus_if.frame_number, bus_if.error, bus_if.decoder_select} !== '0) begin n_bad++; $display("FAIL mid_rst_state got fa=%b ln=%0d fn=%0d err=%b dec=%0d want 0", bus_if.frame_active, bus_if.line_number, bus_if.frame_number, bus_if.error, bus_if.decoder_select); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_word(32'h88888888);
        n_cmp++; if (o_en !== 1'b0) begin n_bad++; $display("FAIL post_rst_idle got %b want 0", o_en); end
        send_hdr(2'd0, DT_FS, 16'd0, 1'b0);
        n_cmp++; if (bus_if.frame_number !== 16'd1 || bus_if.line_number !== 16'd0) begin n_bad++; $display("FAIL post_rst_fs got fn=%0d ln=%0d want 1/0", bus_if.frame_number, bus_if.line_number); end
        send_hdr(2'd0, DT_RAW8, 16'd4, 1'b0);
        send_word(32'h99999999);
        n_cmp++; if ({o_en, o_be, o_last} !== {1'b1, 4'hF, 1'b1}) begin n_bad++; $display("FAIL post_rst_pkt got en=%b be=%h last=%b want 1/f/1", o_en, o_be, o_last); end
    endtask

    initial begin
        bus_if.header_valid    = 1'b0;
        bus_if.virtual_channel = 2'd0;
        bus_if.data_type       = 6'd0;
        bus_if.word_count      = 16'd0;
        bus_if.payload_data    = 32'd0;
        bus_if.payload_valid   = 1'b0;
        bus_if.error_clear     = 1'b0;
        test_reset();
        test_no_frame();
        test_rgb565();
        test_raw8_partial();
        test_vc_drop();
        test_unsupported();
        test_truncate();
        test_zero_wc();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
